sfifo_f1024x18: RTL and testbench

SFIFO_F1024X18 -- requirements
Module: sfifo_f1024x18

---
 rtl/sfifo_pkg.sv | 24 ++
 rtl/sfifo_f1024x18_if.sv | 30 +++
 rtl/sfifo_ram.sv | 38 +++
 rtl/sfifo_f1024x18.sv | 89 ++++++++
 tb/tb_sfifo_f1024x18.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/sfifo_pkg.sv
// Shared defaults and the registered status-flag bundle for the 1024x18
// first-word-fall-through FIFO.
package sfifo_pkg;

    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FULL_WM    = 768;
    localparam int DEF_EMPTY_WM   = 256;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic full_wm;
        logic empty_wm;
        logic overrun;
        logic underrun;
    } flags_t;

    // Flag values right after a flush: nothing stored, so only the "low" indicators are set.
    localparam flags_t FLAGS_FLUSH = '{empty: 1'b1, empty_wm: 1'b1, default: 1'b0};

endpackage

// File: rtl/sfifo_f1024x18_if.sv
// FIFO user-side bundle: write/read requests, head-of-queue data and status flags.
// The FIFO takes the slave view, the user logic the master view.
interface sfifo_f1024x18_if #(
    parameter int DATA_WIDTH = sfifo_pkg::DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] DIN;
    logic                  PUSH;
    logic                  POP;
    logic [DATA_WIDTH-1:0] DOUT;
    logic                  Full;
    logic                  Empty;
    logic                  Almost_Full;
    logic                  Almost_Empty;
    logic                  Full_Watermark;
    logic                  Empty_Watermark;
    logic                  Overrun_Error;
    logic                  Underrun_Error;

    modport master (
        output DIN, PUSH, POP,
        input  DOUT, Full, Empty, Almost_Full, Almost_Empty,
               Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error
    );

    modport slave (
        input  DIN, PUSH, POP,
        output DOUT, Full, Empty, Almost_Full, Almost_Empty,
               Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error
    );
endinterface

// File: rtl/sfifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port, shaped to
// map onto a single block RAM. The read register carries the reset (BRAM output reset).
module sfifo_ram #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset; clearing it would defeat block-RAM inference and
    // the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking assignments everywhere in sequential logic, so a read and a write
    // on the same edge see the pre-edge memory contents (read-first) in simulation too.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sfifo_f1024x18.sv
// 1024x18 synchronous FWFT FIFO: binary pointers, registered flags, and a RAM read
// port aimed at the post-edge head so DOUT is the RAM output register itself.
module sfifo_f1024x18
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FULL_WM    = DEF_FULL_WM,
    parameter int EMPTY_WM   = DEF_EMPTY_WM
) (
    input  logic             clock0,
    input  logic             Async_Flush,
    sfifo_f1024x18_if.slave  fifo_if
);
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int DEPTH     = 2**ADDR_WIDTH;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    localparam ptr_t DEPTH_P    = ptr_t'(DEPTH);
    localparam ptr_t FULL_WM_P  = ptr_t'(FULL_WM);
    localparam ptr_t EMPTY_WM_P = ptr_t'(EMPTY_WM);

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    ptr_t   count_d;
    flags_t flags_q, flags_d;
    logic   push_ok, pop_ok, rd_en;
    logic [DATA_WIDTH-1:0] ram_dout;

    // NOTE: every variable gets a value at the top of the block, so no path can infer a latch.
    always_comb begin
        flags_d  = '0;
        push_ok  = fifo_if.PUSH && !flags_q.full;
        pop_ok   = fifo_if.POP && !flags_q.empty;
        wr_ptr_d = wr_ptr_q + ptr_t'(push_ok);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_ok);
        count_d  = wr_ptr_d - rd_ptr_d;

        // The head word is only readable once it was written on an earlier edge;
        // a word written this edge becomes visible one edge later.
        rd_en = (wr_ptr_q != rd_ptr_d);

        flags_d.full         = (count_d == DEPTH_P);
        flags_d.empty        = !rd_en;
        flags_d.almost_full  = (count_d == DEPTH_P - ptr_t'(1));
        flags_d.almost_empty = (count_d == ptr_t'(1));
        flags_d.full_wm      = (count_d >= FULL_WM_P);
        flags_d.empty_wm     = (count_d <= EMPTY_WM_P);
        flags_d.overrun      = fifo_if.PUSH && flags_q.full;
        flags_d.underrun     = fifo_if.POP && flags_q.empty;
    end

    always_ff @(posedge clock0) begin
        if (Async_Flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            flags_q  <= FLAGS_FLUSH;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
        end
    end

    sfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clock0),
        .rst_i     (Async_Flush),
        .wr_en_i   (push_ok && !Async_Flush),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (fifo_if.DIN),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_d[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_dout)
    );

    assign fifo_if.DOUT            = ram_dout;
    assign fifo_if.Full            = flags_q.full;
    assign fifo_if.Empty           = flags_q.empty;
    assign fifo_if.Almost_Full     = flags_q.almost_full;
    assign fifo_if.Almost_Empty    = flags_q.almost_empty;
    assign fifo_if.Full_Watermark  = flags_q.full_wm;
    assign fifo_if.Empty_Watermark = flags_q.empty_wm;
    assign fifo_if.Overrun_Error   = flags_q.overrun;
    assign fifo_if.Underrun_Error  = flags_q.underrun;
endmodule

// File: tb/tb_sfifo_f1024x18.sv
// Self-checking bench for sfifo_f1024x18: directed fill/drain/error/flush steps plus
// randomized traffic, all compared against a queue-based model of the FIFO rules.
module tb_sfifo_f1024x18;
    localparam int DW       = 18;
    localparam int AW       = 10;
    localparam int DEPTH    = 1024;
    localparam int FULL_WM  = 768;
    localparam int EMPTY_WM = 256;

    logic clk;
    logic flush;

    sfifo_f1024x18_if #(.DATA_WIDTH(DW)) fifo_if ();

    sfifo_f1024x18 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FULL_WM    (FULL_WM),
        .EMPTY_WM   (EMPTY_WM)
    ) dut (
        .clock0      (clk),
        .Async_Flush (flush),
        .fifo_if     (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stored words in arrival order; a word is visible on DOUT one
    // edge after the edge that wrote it; DOUT keeps its last value while nothing is visible.
    int unsigned model_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_empty;
    logic          exp_ovr;
    logic          exp_und;

    int n_compared;
    int n_mismatched;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] w(input int a);
        int unsigned v;
        v = (a | 32'h55000);
        return DW'(v);
    endfunction

    task automatic check_all();
        int sz;
        sz = model_q.size();
        check("dout",      32'(fifo_if.DOUT),            32'(exp_dout));
        check("empty",     32'(fifo_if.Empty),           32'(exp_empty));
        check("full",      32'(fifo_if.Full),            32'(sz == DEPTH));
        check("alm_full",  32'(fifo_if.Almost_Full),     32'(sz == DEPTH - 1));
        check("alm_empty", 32'(fifo_if.Almost_Empty),    32'(sz == 1));
        check("full_wm",   32'(fifo_if.Full_Watermark),  32'(sz >= FULL_WM));
        check("empty_wm",  32'(fifo_if.Empty_Watermark), 32'(sz <= EMPTY_WM));
        check("overrun",   32'(fifo_if.Overrun_Error),   32'(exp_ovr));
        check("underrun",  32'(fifo_if.Underrun_Error),  32'(exp_und));
    endtask

    task automatic step(input logic fl, input logic push, input logic pop, input logic [DW-1:0] din);
        logic push_ok;
        logic pop_ok;
        flush        = fl;
        fifo_if.PUSH = push;
        fifo_if.POP  = pop;
        fifo_if.DIN  = din;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            exp_dout  = '0;
            exp_empty = 1'b1;
            exp_ovr   = 1'b0;
            exp_und   = 1'b0;
        end else begin
            exp_ovr = push && (model_q.size() == DEPTH);
            exp_und = pop && exp_empty;
            push_ok = push && (model_q.size() != DEPTH);
            pop_ok  = pop && !exp_empty;
            if (pop_ok) void'(model_q.pop_front());
            if (model_q.size() != 0) begin
                exp_dout  = DW'(model_q[0]);
                exp_empty = 1'b0;
            end else begin
                exp_empty = 1'b1;
            end
            if (push_ok) model_q.push_back(32'(din));
        end
        #1;
        check_all();
    endtask

    initial begin
        int push_pct;
        int pop_pct;
        int seg_len;
        n_compared   = 0;
        n_mismatched = 0;
        exp_dout     = '0;
        exp_empty    = 1'b1;
        exp_ovr      = 1'b0;
        exp_und      = 1'b0;
        flush        = 1'b1;
        fifo_if.PUSH = 1'b0;
        fifo_if.POP  = 1'b0;
        fifo_if.DIN  = '0;

        // Flush for 40 ns, then fill with w(a).
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, 1'b0, w(a));
        check("fill_full", 32'(fifo_if.Full), 32'd1);
        check("fill_head", 32'(fifo_if.DOUT), 32'h15000);

        // Push while full: dropped, one-cycle overrun.
        step(1'b0, 1'b1, 1'b0, DW'(32'h3FFFF));
        check("ovr_pulse", 32'(fifo_if.Overrun_Error), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        check("ovr_clear", 32'(fifo_if.Overrun_Error), 32'd0);

        // Drain; DOUT walks w(1)..w(1023) and holds the last word once empty.
        for (int k = 1; k <= DEPTH; k++) step(1'b0, 1'b0, 1'b1, '0);
        check("drain_last", 32'(fifo_if.DOUT), 32'h153FF);
        check("drain_empty", 32'(fifo_if.Empty), 32'd1);

        // Pop while empty, then FWFT latency of a single word.
        step(1'b0, 1'b0, 1'b1, '0);
        check("und_pulse", 32'(fifo_if.Underrun_Error), 32'd1);
        step(1'b0, 1'b1, 1'b0, DW'(32'h2AAAA));
        step(1'b0, 1'b0, 1'b0, '0);
        check("fwft_dout", 32'(fifo_if.DOUT), 32'h2AAAA);
        check("fwft_empty", 32'(fifo_if.Empty), 32'd0);

        // Half full, then simultaneous push+pop across pointer wrap.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 1'b1, DW'($urandom));

        // Down to 300 entries, flush, then only new data comes back.
        for (int i = 0; i < 212; i++) step(1'b0, 1'b0, 1'b1, '0);
        check("pre_flush_ae", 32'(fifo_if.Empty_Watermark), 32'd0);
        step(1'b1, 1'b1, 1'b1, DW'($urandom));
        check("flush_dout", 32'(fifo_if.DOUT), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Randomized traffic: fill-heavy, drain-heavy, then balanced with rare flushes.
        for (int seg = 0; seg < 3; seg++) begin
            push_pct = (seg == 0) ? 85 : (seg == 1) ? 20 : 50;
            pop_pct  = (seg == 0) ? 30 : (seg == 1) ? 85 : 50;
            seg_len  = (seg == 0) ? 2600 : (seg == 1) ? 2000 : 1500;
            for (int i = 0; i < seg_len; i++) begin
                step((seg == 2) && ($urandom_range(0, 499) == 0),
                     $urandom_range(0, 99) < push_pct,
                     $urandom_range(0, 99) < pop_pct,
                     DW'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
